// File: rtl/s_machine_pkg.sv
// Shared S-Machine definitions: bus widths, the halt encoding and the fetch-stage state type.
// Imported by the fetch unit and its interface.
package s_machine_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INST_W  = 16;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned WAIT_W  = 3;

    localparam logic [INST_W-1:0] HALT_INST = 16'hFFFF;

    typedef logic [WAIT_W-1:0]  wait_cnt_t;
    typedef logic [COUNT_W-1:0] fetch_cnt_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StHalt
    } fetch_state_e;

    // Saturating increment: the issue counter sticks at all-ones instead of wrapping.
    function automatic fetch_cnt_t sat_inc(input fetch_cnt_t value);
        return (value == '1) ? value : value + fetch_cnt_t'(1);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: interpreter handshake plus the unified-memory read port.
// master = fetch unit, slave = interpreter/memory side.
interface inst_fetch_unit_if;
    import s_machine_pkg::*;

    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [INST_W-1:0] mem_data_in;
    logic              bus_grant;
    logic [INST_W-1:0] inst;
    logic              enable;
    logic              halted;
    fetch_cnt_t        fetch_count;

    modport master (
        input  run, pc, done, mem_data_in,
        output mem_addr, mem_rd, bus_grant, inst, enable, halted, fetch_count
    );

    modport slave (
        output run, pc, done, mem_data_in,
        input  mem_addr, mem_rd, bus_grant, inst, enable, halted, fetch_count
    );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: reads the word at the interpreter's PC, holds it on inst with
// enable high until done, and owns the memory bus only while a read is in flight.
module inst_fetch_unit
    import s_machine_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_unit_if.master bus
);

    localparam wait_cnt_t WAIT_INIT = wait_cnt_t'(MEM_LATENCY - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    wait_cnt_t         wait_cnt_q, wait_cnt_d;
    fetch_cnt_t        fetch_count_q, fetch_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            mem_addr_q    <= '0;
            inst_q        <= '0;
            wait_cnt_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            inst_q        <= inst_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        inst_d        = inst_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.run) begin
                    state_d    = StFetch;
                    mem_addr_d = bus.pc;
                end
            end
            StFetch: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = StWait;
            end
            StWait: begin
                // Counter at zero marks the cycle in which memory data is valid.
                if (wait_cnt_q == '0) begin
                    inst_d = bus.mem_data_in;
                    if (bus.mem_data_in == HALT_INST) begin
                        state_d = StHalt;
                    end else begin
                        state_d       = StIssue;
                        fetch_count_d = sat_inc(fetch_count_q);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - wait_cnt_t'(1);
                end
            end
            StIssue: begin
                // run is only consulted at retirement, so a drop mid-fetch still issues.
                if (bus.done) begin
                    if (bus.run) begin
                        state_d    = StFetch;
                        mem_addr_d = bus.pc;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = (state_q == StFetch);
    assign bus.bus_grant   = (state_q == StFetch) || (state_q == StWait);
    assign bus.inst        = inst_q;
    assign bus.enable      = (state_q == StIssue);
    assign bus.halted      = (state_q == StHalt);
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: two instances (latency 1 and 3) fed by behavioural memories,
// with expectations derived from fetch/issue timing rules and a word-addressed memory image.
module tb_inst_fetch_unit;
    import s_machine_pkg::*;

    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    inst_fetch_unit_if bus_a ();
    inst_fetch_unit_if bus_b ();

    inst_fetch_unit #(.MEM_LATENCY(LAT_A)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    inst_fetch_unit #(.MEM_LATENCY(LAT_B)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    int checks = 0;
    int passed = 0;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] exp_count_a;
    logic [15:0] exp_count_b;

    function automatic logic [15:0] rand_word();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == 16'hFFFF || v == 16'h0000) v = 16'h1234;
        return v;
    endfunction

    // Memory models: data is valid exactly MEM_LATENCY cycles after the mem_rd cycle and
    // random garbage in every other cycle. A pending read is delivered even across a reset.
    bit          pend_a = 0, pend_b = 0;
    int          rem_a = 0, rem_b = 0;
    logic [7:0]  addr_a, addr_b;

    always @(negedge clk) begin
        if (bus_a.mem_rd === 1'b1) begin
            pend_a = 1; rem_a = LAT_A; addr_a = bus_a.mem_addr;
        end else if (pend_a) rem_a--;
        if (pend_a && rem_a == 0) begin
            bus_a.mem_data_in = mem_a[addr_a]; pend_a = 0;
        end else bus_a.mem_data_in = 16'($urandom);
    end

    always @(negedge clk) begin
        if (bus_b.mem_rd === 1'b1) begin
            pend_b = 1; rem_b = LAT_B; addr_b = bus_b.mem_addr;
        end else if (pend_b) rem_b--;
        if (pend_b && rem_b == 0) begin
            bus_b.mem_data_in = mem_b[addr_b]; pend_b = 0;
        end else bus_b.mem_data_in = 16'($urandom);
    end

    task automatic test_reset();
        rst_a = 1; rst_b = 1;
        bus_a.run = 0; bus_a.pc = '0; bus_a.done = 0;
        bus_b.run = 0; bus_b.pc = '0; bus_b.done = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.inst !== 16'h0) $display("FAIL reset_inst got %h want 0000", bus_a.inst); else passed++;
        checks++; if (bus_a.enable !== 1'b0) $display("FAIL reset_enable got %b want 0", bus_a.enable); else passed++;
        checks++; if (bus_a.mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %b want 0", bus_a.mem_rd); else passed++;
        checks++; if (bus_a.mem_addr !== 8'h0) $display("FAIL reset_mem_addr got %h want 00", bus_a.mem_addr); else passed++;
        checks++; if (bus_a.bus_grant !== 1'b0) $display("FAIL reset_bus_grant got %b want 0", bus_a.bus_grant); else passed++;
        checks++; if (bus_a.halted !== 1'b0) $display("FAIL reset_halted got %b want 0", bus_a.halted); else passed++;
        checks++; if (bus_a.fetch_count !== 16'h0) $display("FAIL reset_count got %h want 0000", bus_a.fetch_count); else passed++;
        rst_a = 0; rst_b = 0;
        exp_count_a = 0; exp_count_b = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_a.enable, bus_a.mem_rd, bus_a.bus_grant} !== 3'b000)
            $display("FAIL idle_no_run got en/rd/gnt=%b want 000",
                     {bus_a.enable, bus_a.mem_rd, bus_a.bus_grant});
        else passed++;
    endtask

    task automatic test_first_fetch();
        mem_a[0] = 16'h0401;
        bus_a.pc = 8'h00; bus_a.run = 1;
        @(negedge clk);
        checks++;
        if ({bus_a.mem_rd, bus_a.bus_grant, bus_a.enable, bus_a.mem_addr} !== {3'b110, 8'h00})
            $display("FAIL first_fetch_cycle1 got rd/gnt/en=%b addr=%h want 110 addr=00",
                     {bus_a.mem_rd, bus_a.bus_grant, bus_a.enable}, bus_a.mem_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus_a.mem_rd, bus_a.bus_grant, bus_a.enable} !== 3'b010)
            $display("FAIL first_fetch_wait got rd/gnt/en=%b want 010",
                     {bus_a.mem_rd, bus_a.bus_grant, bus_a.enable});
        else passed++;
        @(negedge clk);
        exp_count_a = 1;
        checks++;
        if ({bus_a.enable, bus_a.bus_grant, bus_a.inst} !== {2'b10, 16'h0401})
            $display("FAIL first_fetch_issue got en/gnt=%b inst=%h want 10 inst=0401",
                     {bus_a.enable, bus_a.bus_grant}, bus_a.inst);
        else passed++;
        checks++;
        if (bus_a.fetch_count !== exp_count_a)
            $display("FAIL first_fetch_count got %0d want %0d", bus_a.fetch_count, exp_count_a);
        else passed++;
    endtask

    task automatic test_hold_and_next();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({bus_a.enable, bus_a.bus_grant, bus_a.mem_rd, bus_a.inst} !== {3'b100, 16'h0401})
                bad++;
        end
        checks++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else passed++;
        mem_a[1] = rand_word();
        bus_a.pc = 8'h01; bus_a.done = 1;
        @(negedge clk);
        bus_a.done = 0;
        checks++;
        if ({bus_a.mem_rd, bus_a.enable, bus_a.mem_addr} !== {2'b10, 8'h01})
            $display("FAIL next_fetch got rd/en=%b addr=%h want 10 addr=01",
                     {bus_a.mem_rd, bus_a.enable}, bus_a.mem_addr);
        else passed++;
        repeat (2) @(negedge clk);
        exp_count_a = 2;
        checks++;
        if ({bus_a.enable, bus_a.inst, bus_a.fetch_count} !== {1'b1, mem_a[1], exp_count_a})
            $display("FAIL next_issue got en=%b inst=%h cnt=%0d want 1 inst=%h cnt=%0d",
                     bus_a.enable, bus_a.inst, bus_a.fetch_count, mem_a[1], exp_count_a);
        else passed++;
    endtask

    task automatic test_idle();
        int bad;
        logic [7:0] p;
        bad = 0;
        bus_a.run = 0; bus_a.done = 1;
        @(negedge clk);
        bus_a.done = 0;
        for (int i = 0; i < 20; i++) begin
            if ({bus_a.enable, bus_a.mem_rd, bus_a.bus_grant} !== 3'b000) bad++;
            bus_a.done = 1'($urandom);
            bus_a.pc = 8'($urandom);
            @(negedge clk);
        end
        checks++; if (bad != 0) $display("FAIL idle_quiet got %0d bad cycles want 0", bad); else passed++;
        p = 8'($urandom);
        mem_a[p] = rand_word();
        bus_a.done = 0; bus_a.pc = p; bus_a.run = 1;
        @(negedge clk);
        checks++;
        if ({bus_a.mem_rd, bus_a.mem_addr} !== {1'b1, p})
            $display("FAIL idle_resume got rd=%b addr=%h want 1 addr=%h",
                     bus_a.mem_rd, bus_a.mem_addr, p);
        else passed++;
        repeat (2) @(negedge clk);
        exp_count_a++;
        checks++;
        if ({bus_a.enable, bus_a.inst, bus_a.fetch_count} !== {1'b1, mem_a[p], exp_count_a})
            $display("FAIL idle_resume_issue got en=%b inst=%h cnt=%0d want 1 inst=%h cnt=%0d",
                     bus_a.enable, bus_a.inst, bus_a.fetch_count, mem_a[p], exp_count_a);
        else passed++;
    endtask

    // Random retire/idle sequence; each instruction must issue L+2 cycles after its kick.
    task automatic test_back_to_back();
        logic [7:0]  p;
        logic [15:0] held;
        int          hold, idle;
        bit          go_idle;
        for (int it = 0; it < 40; it++) begin
            p = (it == 5) ? 8'hFF : 8'($urandom);
            mem_a[p] = rand_word();
            held = bus_a.inst;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if ({bus_a.enable, bus_a.inst} !== {1'b1, held})
                    $display("FAIL b2b_hold it=%0d got en=%b inst=%h want 1 inst=%h",
                             it, bus_a.enable, bus_a.inst, held);
                else passed++;
            end
            go_idle = ($urandom_range(0, 5) == 0);
            if (go_idle) begin
                bus_a.run = 0; bus_a.pc = 8'($urandom); bus_a.done = 1;
                idle = $urandom_range(1, 4);
                for (int k = 0; k < idle; k++) begin
                    @(negedge clk);
                    bus_a.done = 1'($urandom);
                    checks++;
                    if ({bus_a.enable, bus_a.mem_rd} !== 2'b00)
                        $display("FAIL b2b_idle it=%0d got en/rd=%b want 00",
                                 it, {bus_a.enable, bus_a.mem_rd});
                    else passed++;
                end
                bus_a.done = 0; bus_a.pc = p; bus_a.run = 1;
            end else begin
                bus_a.pc = p; bus_a.run = 1; bus_a.done = 1;
            end
            @(negedge clk);
            checks++;
            if ({bus_a.mem_rd, bus_a.enable, bus_a.mem_addr} !== {2'b10, p})
                $display("FAIL b2b_fetch it=%0d got rd/en=%b addr=%h want 10 addr=%h",
                         it, {bus_a.mem_rd, bus_a.enable}, bus_a.mem_addr, p);
            else passed++;
            bus_a.done = 1'($urandom); bus_a.run = 1'($urandom); bus_a.pc = 8'($urandom);
            for (int j = 1; j <= int'(LAT_A) + 1; j++) begin
                @(negedge clk);
                if (j <= int'(LAT_A)) begin
                    checks++;
                    if ({bus_a.enable, bus_a.bus_grant, bus_a.mem_rd} !== 3'b010)
                        $display("FAIL b2b_wait it=%0d got en/gnt/rd=%b want 010",
                                 it, {bus_a.enable, bus_a.bus_grant, bus_a.mem_rd});
                    else passed++;
                    bus_a.done = 1'($urandom); bus_a.run = 1'($urandom); bus_a.pc = 8'($urandom);
                end else begin
                    if (exp_count_a != 16'hFFFF) exp_count_a++;
                    checks++;
                    if ({bus_a.enable, bus_a.inst, bus_a.fetch_count} !== {1'b1, mem_a[p], exp_count_a})
                        $display("FAIL b2b_issue it=%0d got en=%b inst=%h cnt=%0d want 1 inst=%h cnt=%0d",
                                 it, bus_a.enable, bus_a.inst, bus_a.fetch_count, mem_a[p], exp_count_a);
                    else passed++;
                    bus_a.done = 0; bus_a.run = 1;
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] p;
        int         en_seen, rd_seen;
        p = 8'($urandom);
        mem_a[p] = HALT_INST;
        bus_a.pc = p; bus_a.run = 1; bus_a.done = 1;
        @(negedge clk);
        bus_a.done = 0;
        checks++;
        if ({bus_a.mem_rd, bus_a.mem_addr} !== {1'b1, p})
            $display("FAIL halt_fetch got rd=%b addr=%h want 1 addr=%h", bus_a.mem_rd, bus_a.mem_addr, p);
        else passed++;
        en_seen = 0; rd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_a.enable === 1'b1) en_seen++;
            if (bus_a.mem_rd === 1'b1) rd_seen++;
            bus_a.done = 1'($urandom);
        end
        bus_a.done = 0;
        checks++; if (en_seen != 0) $display("FAIL halt_enable got %0d cycles want 0", en_seen); else passed++;
        checks++; if (rd_seen != 0) $display("FAIL halt_mem_rd got %0d reads want 0", rd_seen); else passed++;
        checks++; if (bus_a.halted !== 1'b1) $display("FAIL halt_flag got %b want 1", bus_a.halted); else passed++;
        checks++;
        if (bus_a.fetch_count !== exp_count_a)
            $display("FAIL halt_count got %0d want %0d", bus_a.fetch_count, exp_count_a);
        else passed++;
        rst_a = 1; bus_a.run = 0;
        @(negedge clk);
        rst_a = 0;
        exp_count_a = 0;
        mem_a[p] = rand_word();
        checks++;
        if ({bus_a.halted, bus_a.fetch_count, bus_a.inst} !== {1'b0, 16'h0, 16'h0})
            $display("FAIL halt_reset got halted=%b cnt=%0d inst=%h want 0 0 0000",
                     bus_a.halted, bus_a.fetch_count, bus_a.inst);
        else passed++;
    endtask

    task automatic test_latency3();
        logic [7:0] p;
        int         gnt, first_gnt, last_gnt;
        p = 8'($urandom);
        mem_b[p] = 16'h4000;
        bus_b.pc = p; bus_b.run = 1;
        gnt = 0; first_gnt = -1; last_gnt = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus_b.bus_grant === 1'b1) begin
                gnt++; if (first_gnt < 0) first_gnt = c; last_gnt = c;
            end
            if (c == 1) begin
                checks++;
                if ({bus_b.mem_rd, bus_b.mem_addr} !== {1'b1, p})
                    $display("FAIL lat3_fetch got rd=%b addr=%h want 1 addr=%h",
                             bus_b.mem_rd, bus_b.mem_addr, p);
                else passed++;
            end
            if (c == int'(LAT_B) + 1) begin
                checks++;
                if (bus_b.enable !== 1'b0) $display("FAIL lat3_early_enable got 1 want 0"); else passed++;
            end
            if (c == int'(LAT_B) + 2) begin
                exp_count_b++;
                checks++;
                if ({bus_b.enable, bus_b.inst} !== {1'b1, 16'h4000})
                    $display("FAIL lat3_issue got en=%b inst=%h want 1 inst=4000",
                             bus_b.enable, bus_b.inst);
                else passed++;
            end
        end
        checks++;
        if (gnt != 4 || first_gnt != 1 || last_gnt != 4)
            $display("FAIL lat3_grant got %0d cycles (%0d..%0d) want 4 (1..4)", gnt, first_gnt, last_gnt);
        else passed++;
        // Second fetch from retirement: enable must return exactly L+2 cycles after done.
        p = 8'($urandom);
        mem_b[p] = rand_word();
        bus_b.pc = p; bus_b.done = 1;
        for (int c = 1; c <= int'(LAT_B) + 2; c++) begin
            @(negedge clk);
            bus_b.done = 0; bus_b.pc = 8'($urandom);
            if (c == int'(LAT_B) + 1) begin
                checks++;
                if (bus_b.enable !== 1'b0) $display("FAIL lat3_done_early got 1 want 0"); else passed++;
            end
        end
        exp_count_b++;
        checks++;
        if ({bus_b.enable, bus_b.inst, bus_b.fetch_count} !== {1'b1, mem_b[p], exp_count_b})
            $display("FAIL lat3_done_issue got en=%b inst=%h cnt=%0d want 1 inst=%h cnt=%0d",
                     bus_b.enable, bus_b.inst, bus_b.fetch_count, mem_b[p], exp_count_b);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] q;
        int         bad;
        q = 8'($urandom);
        mem_b[q] = rand_word();
        bus_b.pc = q; bus_b.run = 1; bus_b.done = 1;
        @(negedge clk);
        bus_b.done = 0;
        @(negedge clk);
        checks++;
        if ({bus_b.bus_grant, bus_b.mem_rd} !== 2'b10)
            $display("FAIL midwait_in_wait got gnt/rd=%b want 10", {bus_b.bus_grant, bus_b.mem_rd});
        else passed++;
        rst_b = 1; bus_b.run = 0;
        @(negedge clk);
        rst_b = 0;
        checks++;
        if ({bus_b.inst, bus_b.enable, bus_b.mem_rd, bus_b.mem_addr, bus_b.bus_grant,
             bus_b.halted, bus_b.fetch_count} !== {16'h0, 2'b00, 8'h00, 2'b00, 16'h0})
            $display("FAIL midwait_reset got inst=%h en=%b rd=%b addr=%h gnt=%b halt=%b cnt=%0d want all 0",
                     bus_b.inst, bus_b.enable, bus_b.mem_rd, bus_b.mem_addr, bus_b.bus_grant,
                     bus_b.halted, bus_b.fetch_count);
        else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({bus_b.inst, bus_b.enable, bus_b.bus_grant} !== {16'h0, 2'b00}) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL midwait_late_data got %0d bad cycles want 0", bad);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = rand_word();
            mem_b[i] = rand_word();
        end
        test_reset();
        test_first_fetch();
        test_hold_and_next();
        test_idle();
        test_back_to_back();
        test_halt();
        test_latency3();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage sitting directly upstream of the InstInterpreter in the S-Machine CPU.
- Reads the 16-bit instruction word at the interpreter's PC from unified memory and holds it stable on `inst`.
- Asserts `enable` to the interpreter, then waits for its `done` pulse before fetching the next word.
- Owns the memory bus only during the fetch phase; `bus_grant` tells the interpreter when it may drive memory.

Parameters:
- ADDR_W, 8: memory address / PC width.
- INST_W, 16: instruction and memory data width.
- MEM_LATENCY, 1: cycles from the `mem_rd` cycle to the cycle in which `mem_data_in` is valid. Legal range is 1..7.
- HALT_INST, 16'hFFFF: instruction encoding that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  fetch permission; low causes the unit to idle after the current instruction completes.
- pc  in  ADDR_W  next-instruction address from the interpreter.
- done  in  1  single-cycle pulse from the interpreter: current instruction retired.
- mem_addr  out  ADDR_W  fetch address to memory.
- mem_rd  out  1  single-cycle read strobe.
- mem_data_in  in  INST_W  memory read data.
- bus_grant  out  1  1 = fetch unit owns the memory bus; the interpreter must not drive memory.
- inst  out  INST_W  latched instruction to the interpreter.
- enable  out  1  instruction valid; interpreter executes while high.
- halted  out  1  HALT_INST has been fetched.
- fetch_count  out  16  count of instructions issued; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - inst = 0, enable = 0, mem_rd = 0, mem_addr = 0.
  - bus_grant = 0, halted = 0, fetch_count = 0.
  - Wait counter = 0.
- IDLE:
  - bus_grant = 0, enable = 0.
  - If run = 1, go to FETCH next cycle.
- FETCH (exactly 1 cycle):
  - mem_addr <= pc, sampled on entry.
  - mem_rd = 1, bus_grant = 1.
  - Load wait counter with MEM_LATENCY - 1, then go to WAIT.
- WAIT:
  - bus_grant = 1, mem_rd = 0, mem_addr held.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0, `mem_data_in` is valid and is captured into `inst` at that edge, then go to ISSUE.
  - With MEM_LATENCY = 1, WAIT lasts exactly 1 cycle.
- ISSUE:
  - enable = 1, bus_grant = 0, inst held stable.
  - fetch_count increments once on entry.
  - If the captured inst == HALT_INST: enable stays 0, halted <= 1, go to HALT. A halt word is not issued and does not increment fetch_count.
  - On done = 1 with run = 1: go to FETCH; enable drops the cycle after done.
  - On done = 1 with run = 0: go to IDLE.
  - done = 0: remain in ISSUE indefinitely.
- HALT:
  - All strobes 0, halted = 1.
  - Exit only via reset.
- Latency (IDLE, run rising at cycle 0):
  - FETCH at cycle 1.
  - inst valid and enable = 1 at cycle MEM_LATENCY + 2.
  - done-to-next-enable = MEM_LATENCY + 2 cycles.
- Boundary conditions:
  - done outside ISSUE is ignored.
  - run falling during FETCH or WAIT: the fetch completes and the instruction issues; the run = 0 check is made on done.
  - pc changes during WAIT: ignored, since mem_addr is latched.
  - pc = 8'hFF: fetched normally. PC wrap-around is the interpreter's responsibility.
  - reset in any state, including mid-WAIT: immediate return to reset values. The pending read is abandoned and mem_data_in is not captured.
  - fetch_count at 16'hFFFF: holds; no wrap.

Decomposition:
- Shared package `s_machine_pkg`:
  - ADDR_W and INST_W constants.
  - HALT_INST constant.
  - Fetch-state enumeration: IDLE, FETCH, WAIT, ISSUE, HALT.
- Single module; the wait counter is a 3-bit internal register, so no sub-module is needed.

Test Plan:
- Reset, then run = 1, pc = 8'h00, mem returns 16'h0401 (MEM_LATENCY = 1) -> mem_rd pulse with mem_addr = 0 at cycle 1; inst = 16'h0401 and enable = 1 at cycle 3; fetch_count = 1.
- Hold done = 0 for 10 cycles -> inst and enable stable, bus_grant = 0. Then pulse done with pc = 8'h01 -> next mem_rd with mem_addr = 1 exactly 1 cycle later.
- MEM_LATENCY = 3, mem_data_in valid only in the third cycle after mem_rd (16'h4000), garbage otherwise -> inst = 16'h4000; bus_grant high for exactly 4 cycles.
- Pulse done with run = 0 -> IDLE; enable = 0 and no mem_rd for 20 cycles. Raise run -> fetch resumes at the current pc.
- mem returns 16'hFFFF -> halted = 1, enable never asserts, fetch_count unchanged, no further mem_rd. reset -> halted = 0.
- Assert reset during WAIT -> next cycle all outputs at reset values; data arriving afterwards is not captured (inst = 0).
